// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues reads to a 1-cycle synchronous ROM,
// queues returned words in a prefetch buffer and hands them to execute via valid/ready.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  fetch_fault
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t          state, state_next;
    logic [31:0]     fetch_pc;
    logic [31:0]     req_pc;
    logic            pending;
    logic [31:0]     pending_pc;
    logic            pending_drop;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [CW:0]     occ_sum;
    logic [31:0]     fifo_instr [BUF_DEPTH];
    logic [31:0]     fifo_pc    [BUF_DEPTH];

    logic pop, resp_ok, overflow, push, misaligned, room, issue;

    always_comb begin
        pop        = instr_valid & instr_ready;
        resp_ok    = pending & ~pending_drop & (state == RUN);
        // A response landing on a full, non-draining buffer is discarded and
        // refetched from its own PC, so the buffer never exceeds BUF_DEPTH.
        overflow   = resp_ok & ~redirect_valid & ~pop & (count == CW'(BUF_DEPTH));
        push       = resp_ok & ~redirect_valid & ~overflow;
        misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
        occ_sum    = (CW+1)'(count) + (CW+1)'(rom_rd_en) - (CW+1)'(pop);
        room       = occ_sum < (CW+1)'(BUF_DEPTH);
        issue      = (state != FAULT) & ~redirect_valid & ~overflow & room;

        state_next = state;
        case (state)
            IDLE:    state_next = misaligned ? FAULT : RUN;
            RUN:     if (misaligned) state_next = FAULT;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            req_pc       <= '0;
            rom_rd_en    <= 1'b0;
            rom_addr     <= '0;
            pending      <= 1'b0;
            pending_pc   <= '0;
            pending_drop <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            state        <= state_next;
            rom_rd_en    <= issue;
            pending      <= rom_rd_en;
            pending_pc   <= req_pc;
            pending_drop <= rom_rd_en & (redirect_valid | overflow);
            if (issue) begin
                rom_addr <= fetch_pc[ADDR_WIDTH+1:2];
                req_pc   <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (overflow)
                    fetch_pc <= pending_pc;
                else if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= rom_data;
            fifo_pc[wr_ptr]    <= pending_pc;
        end
    end

    // Empty buffer presents a NOP at PC 0.
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0000_0013;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 32'h0000_0000;
    assign fetch_fault = (state == FAULT);

endmodule
